// File: rtl/hilo_muldiv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hilo_muldiv_sequencer: HI/LO owner, 32-step radix-2 mul/div engine  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hilo_muldiv_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  alu_control,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        read_hi,
  input  logic        read_lo,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] HI_output,
  output logic [31:0] LO_output
);

  localparam logic [4:0] C_OP_MULT  = 5'b10000;
  localparam logic [4:0] C_OP_MULTU = 5'b10001;
  localparam logic [4:0] C_OP_DIV   = 5'b10010;
  localparam logic [4:0] C_OP_DIVU  = 5'b10011;
  localparam logic [4:0] C_OP_MTLO  = 5'b10101;
  localparam logic [4:0] C_OP_MTHI  = 5'b10110;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;
  // acc: upper product half / remainder; quo: multiplier+lower half / quotient
  logic [31:0] acc_q, acc_d, quo_q, quo_d, dvs_q, dvs_d;
  logic        neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, op_mul_q, op_mul_d;

  logic        w_signed;
  logic [31:0] w_a_mag, w_b_mag;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_shift;
  logic [33:0] w_div_diff;
  logic [63:0] w_prod;

  assign w_signed    = (alu_control == C_OP_MULT) || (alu_control == C_OP_DIV);
  // Magnitudes wrap modulo 2^32, so 0x80000000 stays 0x80000000 unsigned
  assign w_a_mag     = (w_signed && A[31]) ? (32'd0 - A) : A;
  assign w_b_mag     = (w_signed && B[31]) ? (32'd0 - B) : B;
  assign w_mul_sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, dvs_q} : 33'd0);
  assign w_div_shift = {acc_q, quo_q[31]};
  assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, dvs_q};
  assign w_prod      = neg_res_q ? (64'd0 - {acc_q, quo_q}) : {acc_q, quo_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    acc_d     = acc_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    op_mul_d  = op_mul_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (alu_control)
            C_OP_MTLO: lo_d = A;
            C_OP_MTHI: hi_d = A;
            C_OP_MULT, C_OP_MULTU: begin
              acc_d     = 32'd0;
              quo_d     = w_b_mag;
              dvs_d     = w_a_mag;
              neg_res_d = w_signed & (A[31] ^ B[31]);
              neg_rem_d = 1'b0;
              op_mul_d  = 1'b1;
              cnt_d     = 5'd0;
              state_d   = S_MUL;
            end
            C_OP_DIV, C_OP_DIVU: begin
              // Divide by zero is a silent no-op on HI/LO
              if (B != 32'd0) begin
                acc_d     = 32'd0;
                quo_d     = w_a_mag;
                dvs_d     = w_b_mag;
                neg_res_d = w_signed & (A[31] ^ B[31]);
                neg_rem_d = w_signed & A[31];
                op_mul_d  = 1'b0;
                cnt_d     = 5'd0;
                state_d   = S_DIV;
              end
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = w_mul_sum[32:1];
        quo_d = {w_mul_sum[0], quo_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIXUP;
      end
      S_DIV: begin
        if (!w_div_diff[33]) begin
          acc_d = w_div_diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          acc_d = w_div_shift[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        if (op_mul_q) begin
          hi_d = w_prod[63:32];
          lo_d = w_prod[31:0];
        end else begin
          lo_d = neg_res_q ? (32'd0 - quo_q) : quo_q;
          hi_d = neg_rem_q ? (32'd0 - acc_q) : acc_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
      acc_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      op_mul_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      op_mul_q  <= op_mul_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign stall     = busy & (start | read_hi | read_lo);
  assign done      = done_q;
  assign HI_output = hi_q;
  assign LO_output = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hilo_muldiv_sequencer: directed vectors for the HI/LO sequencer   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_hilo_muldiv_sequencer;

  localparam logic [4:0] C_OP_MULT  = 5'b10000;
  localparam logic [4:0] C_OP_MULTU = 5'b10001;
  localparam logic [4:0] C_OP_DIV   = 5'b10010;
  localparam logic [4:0] C_OP_DIVU  = 5'b10011;
  localparam logic [4:0] C_OP_MTLO  = 5'b10101;
  localparam logic [4:0] C_OP_MTHI  = 5'b10110;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  alu_control;
  logic [31:0] A, B;
  logic        read_hi, read_lo;
  logic        busy, stall, done;
  logic [31:0] HI_output, LO_output;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hilo_muldiv_sequencer u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alu_control(alu_control),
    .A          (A),
    .B          (B),
    .read_hi    (read_hi),
    .read_lo    (read_lo),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .HI_output  (HI_output),
    .LO_output  (LO_output)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one engine op right after an edge and follow it to completion.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    start = 1'b1; alu_control = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check({tag, " busy_cycles"}, 64'(n), 64'd33);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " HI"}, 64'(HI_output), 64'(exp_hi));
    check({tag, " LO"}, 64'(LO_output), 64'(exp_lo));
    @(posedge clk); #1;
    check({tag, " done_pulse_end"}, 64'(done), 64'd0);
  endtask

  task automatic move_to(input logic [4:0] op, input logic [31:0] a);
    start = 1'b1; alu_control = op; A = a; B = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    reset = 1'b1; start = 1'b0; alu_control = 5'd0; A = 32'd0; B = 32'd0;
    read_hi = 1'b0; read_lo = 1'b0;
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst stall", 64'(stall), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst HI", 64'(HI_output), 64'd0);
    check("rst LO", 64'(LO_output), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    run_op("mult_m3x7",   C_OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu_max",   C_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_minsq",  C_OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_m7d2",    C_OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7dm2",    C_OP_DIV,   32'd7,        32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD);
    run_op("div_ovf",     C_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000);

    // DIVU with MFLO waiting from cycle 5 and a stray MULT offered at cycle 3
    start = 1'b1; alu_control = C_OP_DIVU; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; bad = 0;
    while (busy && n < 40) begin
      n++;
      start = (n == 3); alu_control = C_OP_MULT; A = 32'd5; B = 32'd5;
      if (n >= 5) read_lo = 1'b1;
      #1;
      if (stall !== (start | read_lo)) bad++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("divu_stall busy_cycles", 64'(n), 64'd33);
    check("divu_stall stall_pattern_errs", 64'(bad), 64'd0);
    check("divu_stall stall_in_done", 64'(stall), 64'd0);
    check("divu_stall done", 64'(done), 64'd1);
    check("divu_stall LO", 64'(LO_output), 64'd14);
    check("divu_stall HI", 64'(HI_output), 64'd2);
    read_lo = 1'b0;
    @(posedge clk); #1;

    move_to(C_OP_MTLO, 32'h22);
    move_to(C_OP_MTHI, 32'h11);
    check("mt HI", 64'(HI_output), 64'h11);
    check("mt LO", 64'(LO_output), 64'h22);

    // DIVU by zero leaves everything untouched
    start = 1'b1; alu_control = C_OP_DIVU; A = 32'd5; B = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("divz busy", 64'(busy), 64'd0);
    check("divz done", 64'(done), 64'd0);
    check("divz HI", 64'(HI_output), 64'h11);
    check("divz LO", 64'(LO_output), 64'h22);
    @(posedge clk); #1;
    check("divz done_later", 64'(done), 64'd0);

    move_to(C_OP_MTHI, 32'h1234);
    check("mthi HI", 64'(HI_output), 64'h1234);
    check("mthi LO", 64'(LO_output), 64'h22);

    // Reset mid-MULT aborts immediately
    start = 1'b1; alu_control = C_OP_MULT; A = 32'd3; B = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst HI", 64'(HI_output), 64'd0);
    check("midrst LO", 64'(LO_output), 64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    run_op("multu_after_rst", C_OP_MULTU, 32'd100000, 32'd100000, 32'h0000_0002, 32'h540B_E400);
    run_op("multu_shift",     C_OP_MULTU, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hilo_muldiv_sequencer.md
# hilo_muldiv_sequencer

Multi-cycle multiply/divide sequencer for the MIPS core. It owns the architectural HI/LO registers and runs MULT/MULTU/DIV/DIVU as a 32-iteration radix-2 shift-add or restoring-divide engine. It executes MTHI/MTLO directly and raises `stall` to the pipeline when an instruction needs HI/LO or the unit while it is busy. It sits beside the ALU in the execute stage and replaces the ALU's single-cycle product/quotient path for HI/LO.

## Interface
Parameters:
- none (datapath fixed at 32 bits, 32 iterations)

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: execute-stage instruction targets this unit this cycle.
- `alu_control` in 5: team ALU control code. 10000 MULT, 10001 MULTU, 10010 DIV, 10011 DIVU, 10101 MTLO, 10110 MTHI. Any other code with `start`=1 is ignored.
- `A` in 32: rs operand (dividend, multiplicand, MTHI/MTLO source).
- `B` in 32: rt operand (divisor, multiplier).
- `read_hi` in 1: MFHI in execute stage.
- `read_lo` in 1: MFLO in execute stage.
- `busy` out 1: engine running (state ≠ IDLE).
- `stall` out 1: pipeline must hold execute stage this cycle.
- `done` out 1: one-cycle pulse after HI/LO written by an engine op.
- `HI_output` out 32: HI register.
- `LO_output` out 32: LO register.

## Operation
- States: IDLE, MUL, DIV, FIXUP.
- IDLE, `start`, MTHI/MTLO: write A to HI/LO at the edge. Stay IDLE, no `done`.
- IDLE, `start`, MULT/MULTU/DIV/DIVU with B ≠ 0 (or any multiply):
  - Latch operand magnitudes. Signed ops take the absolute value, computed modulo 2^32, so 0x80000000 stays 0x80000000 as unsigned.
  - Latch result-sign flags, clear the 5-bit iteration counter, go to MUL or DIV.
- DIV/DIVU with B == 0: HI/LO unchanged. Stay IDLE, no `done`, completes in zero extra cycles.
- MUL: each edge does one shift-add step on a 64-bit product/multiplier register. After 32 steps (counter 31→wrap), go to FIXUP.
- DIV: each edge does one restoring step on a 33-bit partial remainder plus 32-bit quotient. After 32 steps, go to FIXUP.
- FIXUP, one edge:
  - MULT: negate the 64-bit product if operand signs differ.
  - DIV: negate the quotient if signs differ; negate the remainder if the dividend is negative.
  - Write HI (product[63:32] / remainder) and LO (product[31:0] / quotient).
  - Pulse `done`, go to IDLE.
- Arithmetic is truncated two's complement. 0x80000000 / 0xFFFFFFFF (DIV) gives LO=0x80000000, HI=0.
- `stall` = `busy` & (`start` | `read_hi` | `read_lo`). Combinational, no registered lag.
- `start` while busy is not accepted. The pipeline re-presents the instruction after `busy` falls.
- `HI_output`/`LO_output` always show register contents. Old values remain visible while busy.

## Timing
- Reset (async, immediate): state IDLE, counter 0, HI=0, LO=0, `done`=0. Hence `busy`=0 and `stall`=0.
- Reset mid-operation aborts the engine. HI/LO go to 0, not the partial result.
- Engine op: `start` sampled at edge E0.
  - `busy`=1 from after E0 until E33. Steps run on E1..E32; FIXUP edge is E33.
  - HI/LO and `done` are valid in the cycle after E33, 33 cycles after acceptance.
- `done` is registered, high exactly one cycle.
- `start` in the cycle `done` is high (state IDLE) is accepted normally. Back-to-back ops have no bubble.
- MFHI/MFLO in the `done` cycle reads new values with no stall.
- MTHI/MTLO latency: 1 edge. A read in the next cycle sees the new value.

## Test plan
- MULT A=0xFFFFFFFD (−3), B=7 → after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB; `done` one cycle; `busy` high exactly 33 cycles.
- MULTU A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=100, B=7 → LO=14, HI=2. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- `read_lo`=1 at cycle 5 of a DIV → `stall`=1 every cycle until `busy` drops. `stall`=0 in the `done` cycle, where LO holds the new value. `start` while busy is ignored.
- DIVU B=0 with HI=0x11, LO=0x22 → no busy, no `done`, HI/LO unchanged. MTHI A=0x1234 → HI=0x1234 next cycle, LO unchanged.
- Assert `reset` at cycle 10 of a MULT → `busy`, `done`, HI, LO all 0 immediately. A new MULTU started after release completes correctly.
